// File: rtl/phy_rdata_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phy_rdata_buffer_pkg                                                       |
// | Shared field widths and the packed FIFO entry layout for the read buffer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package phy_rdata_buffer_pkg;

    localparam int c_DATA_W          = 32;
    localparam int c_ID_W            = 16;
    localparam int c_USER_W          = 16;
    localparam int c_RD_SPACE_THRESH = 16;
    localparam int c_ENTRY_W         = 1 + c_USER_W + c_ID_W + c_DATA_W;

    // One FIFO entry; field order fixes the 65-bit {last,user,id,data} layout.
    typedef struct packed {
        logic                  last;
        logic [c_USER_W-1:0]   user;
        logic [c_ID_W-1:0]     id;
        logic [c_DATA_W-1:0]   data;
    } beat_t;

endpackage

`default_nettype wire

// File: rtl/phy_rdata_buffer_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phy_rdata_buffer_fifo                                                      |
// | Show-ahead synchronous FIFO with next-count output and drop-on-full.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module phy_rdata_buffer_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count_next,
    output logic             drop
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_accept;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_pop    = ~w_empty & pop_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign w_accept = push & (~w_full | w_pop);
    assign drop     = push & w_full & ~w_pop;

    assign count_next = r_count + CW'(w_accept) - CW'(w_pop);
    assign out_valid  = ~w_empty;
    assign out_data   = w_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wptr] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/phy_rdata_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phy_rdata_buffer                                                           |
// | Retro-tags the late rlast onto held read beats and streams them via FIFO.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module phy_rdata_buffer
    import phy_rdata_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 64,
    parameter int SPACE_THRESH = c_RD_SPACE_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rvalid,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [c_ID_W-1:0]     i_rid,
    input  logic [c_USER_W-1:0]   i_ruser,
    input  logic                  i_rlast,
    output logic                  o_space_ok,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [c_ID_W-1:0]     m_axis_tid,
    output logic [c_USER_W-1:0]   m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  o_overflow,
    output logic                  o_orphan_last,
    input  logic                  i_err_clr
);

    localparam int c_CW = $clog2(FIFO_DEPTH) + 1;

    logic                  r_hold_v;
    logic                  r_pend;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic [c_ID_W-1:0]     r_hold_id;
    logic [c_USER_W-1:0]   r_hold_user;
    logic                  r_space_ok;
    logic                  r_overflow;
    logic                  r_orphan;

    logic                  w_push;
    logic                  w_push_last;
    logic                  w_orphan;
    beat_t                 w_push_beat;
    beat_t                 w_head;
    logic [c_ENTRY_W-1:0]  w_fifo_dout;
    logic [c_CW-1:0]       w_count_next;
    logic [c_CW-1:0]       w_free;
    logic                  w_drop;

    // The held beat leaves when the next beat or an rlast resolves its last bit;
    // a pending (already tagged) beat leaves on the first cycle it can.
    always_comb begin
        w_push      = 1'b0;
        w_push_last = 1'b0;
        w_orphan    = 1'b0;
        if (i_rvalid) begin
            w_push      = r_hold_v;
            w_push_last = r_pend;
        end else if (i_rlast) begin
            w_push      = r_hold_v;
            w_push_last = 1'b1;
            w_orphan    = ~r_hold_v | r_pend;
        end else if (r_hold_v & r_pend) begin
            w_push      = 1'b1;
            w_push_last = 1'b1;
        end
    end

    assign w_push_beat = '{last: w_push_last, user: r_hold_user,
                           id: r_hold_id, data: r_hold_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_v    <= 1'b0;
            r_pend      <= 1'b0;
            r_hold_data <= '0;
            r_hold_id   <= '0;
            r_hold_user <= '0;
        end else if (i_rvalid) begin
            r_hold_v    <= 1'b1;
            r_pend      <= i_rlast;
            r_hold_data <= i_rdata;
            r_hold_id   <= i_rid;
            r_hold_user <= i_ruser;
        end else if (w_push) begin
            r_hold_v    <= 1'b0;
            r_pend      <= 1'b0;
        end
    end

    phy_rdata_buffer_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_data  (w_push_beat),
        .pop_ready  (m_axis_tready),
        .out_valid  (m_axis_tvalid),
        .out_data   (w_fifo_dout),
        .count_next (w_count_next),
        .drop       (w_drop)
    );

    assign w_head        = beat_t'(w_fifo_dout);
    assign m_axis_tdata  = w_head.data;
    assign m_axis_tid    = w_head.id;
    assign m_axis_tuser  = w_head.user;
    assign m_axis_tlast  = w_head.last;

    assign w_free = c_CW'(FIFO_DEPTH) - w_count_next;

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_space_ok <= 1'b0;
            r_overflow <= 1'b0;
            r_orphan   <= 1'b0;
        end else begin
            r_space_ok <= (w_free >= c_CW'(SPACE_THRESH));
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_orphan) begin
                r_orphan <= 1'b1;
            end else if (i_err_clr) begin
                r_orphan <= 1'b0;
            end
        end
    end

    assign o_space_ok    = r_space_ok;
    assign o_overflow    = r_overflow;
    assign o_orphan_last = r_orphan;

endmodule

`default_nettype wire

// File: tb/tb_phy_rdata_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_phy_rdata_buffer                                                        |
// | Directed vector table plus hand-written overflow, orphan and reset cases.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_phy_rdata_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic [15:0] i_rid;
    logic [15:0] i_ruser;
    logic        i_rlast;
    logic        o_space_ok;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [15:0] m_axis_tid;
    logic [15:0] m_axis_tuser;
    logic        m_axis_tlast;
    logic        o_overflow;
    logic        o_orphan_last;
    logic        i_err_clr;

    always #5 clk = ~clk;

    phy_rdata_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .i_rvalid      (i_rvalid),
        .i_rdata       (i_rdata),
        .i_rid         (i_rid),
        .i_ruser       (i_ruser),
        .i_rlast       (i_rlast),
        .o_space_ok    (o_space_ok),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .o_overflow    (o_overflow),
        .o_orphan_last (o_orphan_last),
        .i_err_clr     (i_err_clr)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [15:0] id;
        logic        l;
        logic        ev;
        logic [31:0] ed;
        logic [15:0] eid;
        logic        el;
    } vec_t;

    vec_t tbl[64];
    int   n_vec  = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] user_of(input logic [15:0] id);
        return {4'hA, id[11:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [15:0] id, input logic l);
        i_rvalid = v;
        i_rdata  = d;
        i_rid    = id;
        i_ruser  = user_of(id);
        i_rlast  = l;
    endtask

    task automatic add(input logic v, input logic [31:0] d, input logic [15:0] id, input logic l,
                       input logic ev, input logic [31:0] ed, input logic [15:0] eid, input logic el);
        tbl[n_vec] = '{v: v, d: d, id: id, l: l, ev: ev, ed: ed, eid: eid, el: el};
        n_vec++;
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].id, tbl[i].l);
            cyc();
            chk($sformatf("vec%0d.tvalid", i), 64'(m_axis_tvalid), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d.tdata", i), 64'(m_axis_tdata), 64'(tbl[i].ed));
                chk($sformatf("vec%0d.tid", i), 64'(m_axis_tid), 64'(tbl[i].eid));
                chk($sformatf("vec%0d.tuser", i), 64'(m_axis_tuser), 64'(user_of(tbl[i].eid)));
                chk($sformatf("vec%0d.tlast", i), 64'(m_axis_tlast), 64'(tbl[i].el));
            end
        end
        drive(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Group 1 [0,10): eight back-to-back beats, rlast with the last one.
        for (int b = 0; b < 8; b++) begin
            add(1'b1, 32'(b), 16'h0010, (b == 7), (b >= 1), 32'(b - 1), 16'h0010, 1'b0);
        end
        add(1'b0, '0, '0, 1'b0, 1'b1, 32'h7, 16'h0010, 1'b1);
        add(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        // Group 2 [10,18): four beats, rlast arrives alone three cycles later.
        for (int b = 0; b < 4; b++) begin
            add(1'b1, 32'h100 + 32'(b), 16'h0020, 1'b0, (b >= 1), 32'h100 + 32'(b - 1), 16'h0020, 1'b0);
        end
        add(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        add(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        add(1'b0, '0, '0, 1'b1, 1'b1, 32'h103, 16'h0020, 1'b1);
        add(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        // Group 5 [18,24): command B starts the cycle after A's rlast.
        add(1'b1, 32'h200, 16'h0001, 1'b0, 1'b0, '0, '0, 1'b0);
        add(1'b1, 32'h201, 16'h0001, 1'b1, 1'b1, 32'h200, 16'h0001, 1'b0);
        add(1'b1, 32'h300, 16'h0002, 1'b0, 1'b1, 32'h201, 16'h0001, 1'b1);
        add(1'b1, 32'h301, 16'h0002, 1'b1, 1'b1, 32'h300, 16'h0002, 1'b0);
        add(1'b0, '0, '0, 1'b0, 1'b1, 32'h301, 16'h0002, 1'b1);
        add(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        // Group 6 [24,29): clean packet after a mid-packet reset.
        add(1'b1, 32'h400, 16'h0003, 1'b0, 1'b0, '0, '0, 1'b0);
        add(1'b1, 32'h401, 16'h0003, 1'b0, 1'b1, 32'h400, 16'h0003, 1'b0);
        add(1'b1, 32'h402, 16'h0003, 1'b1, 1'b1, 32'h401, 16'h0003, 1'b0);
        add(1'b0, '0, '0, 1'b0, 1'b1, 32'h402, 16'h0003, 1'b1);
        add(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);

        rst           = 1'b1;
        m_axis_tready = 1'b1;
        i_err_clr     = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        cyc();
        cyc();
        chk("reset.tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("reset.space_ok", 64'(o_space_ok), 64'd0);
        chk("reset.overflow", 64'(o_overflow), 64'd0);
        chk("reset.orphan", 64'(o_orphan_last), 64'd0);
        rst = 1'b0;
        cyc();
        chk("post_reset.space_ok", 64'(o_space_ok), 64'd1);

        run(0, 24);

        // Fill with tready low: space_ok tracks count, 65th beat is dropped.
        m_axis_tready = 1'b0;
        for (int k = 0; k < 66; k++) begin
            int n;
            if (k < 65) drive(1'b1, 32'(k), 16'h0030, (k == 64));
            else        drive(1'b0, '0, '0, 1'b0);
            cyc();
            n = (k < 64) ? k : 64;
            chk($sformatf("fill%0d.space_ok", k), 64'(o_space_ok), 64'((64 - n) >= 16));
            chk($sformatf("fill%0d.overflow", k), 64'(o_overflow), 64'(k == 65));
        end
        drive(1'b0, '0, '0, 1'b0);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("drain%0d.tvalid", i), 64'(m_axis_tvalid), 64'd1);
            chk($sformatf("drain%0d.tdata", i), 64'(m_axis_tdata), 64'(i));
            chk($sformatf("drain%0d.tlast", i), 64'(m_axis_tlast), 64'd0);
            cyc();
        end
        chk("drain.empty", 64'(m_axis_tvalid), 64'd0);
        chk("drain.space_ok", 64'(o_space_ok), 64'd1);
        chk("drain.overflow_sticky", 64'(o_overflow), 64'd1);

        // Orphan rlast, then clear colliding with a new orphan, then a plain clear.
        drive(1'b0, '0, '0, 1'b1);
        cyc();
        drive(1'b0, '0, '0, 1'b0);
        chk("orphan.flag", 64'(o_orphan_last), 64'd1);
        chk("orphan.no_stream", 64'(m_axis_tvalid), 64'd0);
        cyc();
        chk("orphan.no_stream_late", 64'(m_axis_tvalid), 64'd0);
        drive(1'b0, '0, '0, 1'b1);
        i_err_clr = 1'b1;
        cyc();
        drive(1'b0, '0, '0, 1'b0);
        chk("clr_vs_err.orphan", 64'(o_orphan_last), 64'd1);
        chk("clr_vs_err.overflow", 64'(o_overflow), 64'd0);
        cyc();
        i_err_clr = 1'b0;
        chk("clr.orphan", 64'(o_orphan_last), 64'd0);

        // Mid-packet reset with ten beats buffered and an error flag set.
        m_axis_tready = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        cyc();
        for (int k = 0; k < 11; k++) begin
            drive(1'b1, 32'h500 + 32'(k), 16'h0040, 1'b0);
            cyc();
        end
        drive(1'b0, '0, '0, 1'b0);
        chk("pre_rst.tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("pre_rst.orphan", 64'(o_orphan_last), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_axis_tready = 1'b1;
        chk("mid_rst.tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_rst.orphan", 64'(o_orphan_last), 64'd0);
        chk("mid_rst.overflow", 64'(o_overflow), 64'd0);
        cyc();
        chk("mid_rst.space_ok", 64'(o_space_ok), 64'd1);
        chk("mid_rst.still_empty", 64'(m_axis_tvalid), 64'd0);
        run(24, 29);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
